// File: rtl/expr_pkg.sv
// Shared widths, seed, feedback taps and FSM state type for the expression-result MISR.
package expr_pkg;

  localparam int EXPR_Y_W = 90;
  localparam int SIG_W    = 32;
  localparam int CNT_W    = 16;

  localparam logic [SIG_W-1:0] SIG_SEED = 32'hFFFF_FFFF;
  // x^32 + x^22 + x^2 + x + 1: feedback is the parity of sig bits 31, 21, 1, 0
  localparam logic [SIG_W-1:0] SIG_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [SIG_W-1:0] fold(input logic [EXPR_Y_W-1:0] data);
    return data[31:0] ^ data[63:32] ^ {6'b0, data[89:64]};
  endfunction

endpackage

// File: rtl/expr_misr_step.sv
// One combinational MISR step: fold the 90-bit result vector to 32 bits and shift it in.
module expr_misr_step
  import expr_pkg::*;
(
  input  logic [SIG_W-1:0]    sig,
  input  logic [EXPR_Y_W-1:0] data,
  output logic [SIG_W-1:0]    sig_next
);

  logic fb;

  assign fb       = ^(sig & SIG_TAPS);
  assign sig_next = {sig[SIG_W-2:0], fb} ^ fold(data);

endmodule

// File: rtl/expr_result_misr.sv
// Capture-run controller: compresses num_samples accepted result vectors into a MISR signature.
//   state | meaning
//   IDLE  | waiting for start; signature and count hold
//   RUN   | accepting vectors (in_ready=busy=1)
//   DONE  | target reached; signature and count hold until start/clear
module expr_result_misr
  import expr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  input  logic [CNT_W-1:0]    num_samples,
  input  logic                in_valid,
  input  logic [EXPR_Y_W-1:0] in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sample_cnt,
  output logic [SIG_W-1:0]    signature
);

  state_t             state;
  logic [CNT_W-1:0]   target;
  logic [SIG_W-1:0]   sig_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  expr_misr_step u_step (
    .sig      (signature),
    .data     (in_data),
    .sig_next (sig_next)
  );

  assign accept  = in_valid && in_ready;
  assign cnt_inc = sample_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      signature  <= '0;
      sample_cnt <= '0;
      target     <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            signature  <= SIG_SEED;
            sample_cnt <= '0;
            target     <= num_samples;
            if (num_samples != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end else begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            signature  <= sig_next;
            sample_cnt <= cnt_inc;
            // Leave RUN on the accept that reaches the target so the count never wraps
            if (cnt_inc == target) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_result_misr.sv
// Bench for expr_result_misr: constant vector table, hand sequences and randomized runs vs a reference model.
module tb_expr_result_misr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic [15:0] num_samples;
  logic        in_valid;
  logic [89:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [15:0] sample_cnt;
  logic [31:0] signature;

  int total = 0;
  int bad   = 0;

  expr_result_misr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear       (clear),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .signature   (signature)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [89:0] data;
    logic [31:0] exp_sig;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: polynomial x^32+x^22+x^2+x+1 shift with the three 32-bit slices XORed in
  function automatic logic [31:0] model_step(input logic [31:0] sig, input logic [89:0] d);
    logic [31:0] f;
    logic        fb;
    f  = d[31:0] ^ d[63:32] ^ 32'(d[89:64]);
    fb = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];
    return ((sig << 1) | 32'(fb)) ^ f;
  endfunction

  function automatic logic [89:0] rand90();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[89:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  // One run of n accepts; valid pattern either from pat (LSB first) or random. Start pulses
  // during RUN must be ignored, and in_data is X whenever in_valid is low.
  task automatic run_seq(input int n, input bit use_pat, input logic [15:0] pat);
    logic [31:0] esig;
    logic [89:0] d;
    logic        v;
    int          cnt;
    int          cyc;
    do_start(n[15:0]);
    esig = 32'hFFFF_FFFF;
    cnt = 0;
    cyc = 0;
    check("run_entry_busy", {31'b0, busy}, 32'd1);
    while (cnt < n && cyc < 400) begin
      v = use_pat ? pat[cyc % 16] : 1'($urandom_range(0, 1));
      d = rand90();
      in_valid = v;
      in_data  = v ? d : 'x;
      start = ($urandom_range(0, 3) == 0);
      num_samples = 16'($urandom);
      tick();
      if (v) begin
        esig = model_step(esig, d);
        cnt++;
      end
      check("run_sig", signature, esig);
      check("run_cnt", {16'b0, sample_cnt}, cnt);
      check("run_ready", {31'b0, in_ready}, {31'b0, cnt < n});
      check("run_done", {31'b0, done}, {31'b0, cnt >= n});
      cyc++;
    end
    start = 1'b0;
    if (cnt < n) check("run_timeout", cnt, n);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = rand90();
      tick();
      check("done_hold_sig", signature, esig);
      check("done_hold_cnt", {16'b0, sample_cnt}, n);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;

    tbl[0] = '{90'h0,                        32'hFFFF_FFFE};
    tbl[1] = '{90'h1,                        32'hFFFF_FFFF};
    tbl[2] = '{90'h3,                        32'hFFFF_FFFD};
    tbl[3] = '{{57'h0, 1'b1, 32'h0},         32'hFFFF_FFFF};
    tbl[4] = '{{25'h0, 1'b1, 64'h0},         32'hFFFF_FFFF};
    tbl[5] = '{{1'b1, 89'h0},                32'hFDFF_FFFE};
    tbl[6] = '{{26'h0, 32'hFFFF_FFFF, 32'h0}, 32'h0000_0001};
    tbl[7] = '{{26'h3FF_FFFF, 64'h0},        32'hFC00_0001};

    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    in_data = '0;
    tick();
    tick();
    check("rst_sig", signature, 32'h0);
    check("rst_cnt", {16'b0, sample_cnt}, 32'd0);
    check("rst_flags", {29'b0, in_ready, busy, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-sample runs from the table, restarted back to back from DONE
    for (int i = 0; i < 8; i++) begin
      do_start(16'd1);
      in_valid = 1'b1;
      in_data  = tbl[i].data;
      tick();
      in_valid = 1'b0;
      check("tbl_sig", signature, tbl[i].exp_sig);
      check("tbl_cnt", {16'b0, sample_cnt}, 32'd1);
      check("tbl_done", {30'b0, done, in_ready}, 32'd2);
      tick();
    end

    // Zero-sample run goes straight to DONE with the seed
    do_start(16'd0);
    check("zero_done", {29'b0, done, busy, in_ready}, 32'd4);
    check("zero_sig", signature, 32'hFFFF_FFFF);
    check("zero_cnt", {16'b0, sample_cnt}, 32'd0);
    in_valid = 1'b1;
    tick();
    check("zero_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;

    run_seq(4, 1'b1, 16'b0000_0000_0010_1101);

    // Clear after 2 of 5 accepts, competing with a start and a valid vector
    do_start(16'd5);
    in_valid = 1'b1;
    in_data = rand90();
    tick();
    in_data = rand90();
    tick();
    held = signature;
    clear = 1'b1;
    start = 1'b1;
    num_samples = 16'd3;
    in_data = rand90();
    tick();
    clear = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    check("clr_cnt", {16'b0, sample_cnt}, 32'd2);
    check("clr_sig", signature, held);
    check("clr_flags", {29'b0, in_ready, busy, done}, 32'd0);
    tick();
    check("clr_idle_sig", signature, held);
    do_start(16'd1);
    check("restart_seed", signature, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    in_data = '0;
    tick();
    in_valid = 1'b0;
    check("restart_sig", signature, 32'hFFFF_FFFE);

    for (int r = 0; r < 12; r++) run_seq($urandom_range(1, 9), 1'b0, 16'h0);

    // Reset mid-run overrides an accept and discards the partial signature
    do_start(16'd6);
    in_valid = 1'b1;
    in_data = rand90();
    tick();
    rst_n = 1'b0;
    clear = 1'b1;
    in_data = rand90();
    tick();
    rst_n = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_sig", signature, 32'h0);
    check("mid_rst_cnt", {16'b0, sample_cnt}, 32'd0);
    check("mid_rst_flags", {29'b0, in_ready, busy, done}, 32'd0);

    run_seq(3, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
